// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t       : FSM encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/sum width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result handshakes of the bit-serial adder.
//   in_valid/in_ready/a/b/cin   : operand channel (master drives valid/data)
//   out_valid/out_ready/sum/cout: result channel (slave drives valid/data)
//   ovf                          : signed overflow, only with SERIAL_ADDER_OVF_EN
// Modports: master = operand producer / result consumer, slave = the adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/serial_adder_fa_bit.sv
// fa_bit: purely combinational one-bit full adder.
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   carry     : majority(a, b, cin)
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell.
// Operands are accepted in IDLE, added LSB-first over WIDTH SHIFT cycles
// with a registered carry, and presented in DONE until the consumer takes them.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : serial_adder_if.slave (operand and result handshakes)
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed overflow flag ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] acc_reg;   // partial sum, filled from the MSB side
  logic [WIDTH-1:0] sum_reg;   // published result, only updated on completion
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_reg;
`endif

  logic fa_sum;
  logic fa_carry;

  fa_bit u_fa (
    .a     (sa_reg[0]),
    .b     (sb_reg[0]),
    .cin   (carry_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            sa_reg    <= bus.a;
            sb_reg    <= bus.b;
            carry_reg <= bus.cin;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end

        SHIFT: begin
          sa_reg    <= sa_reg >> 1;
          sb_reg    <= sb_reg >> 1;
          carry_reg <= fa_carry;
          acc_reg   <= {fa_sum, acc_reg[WIDTH-1:1]};
          if (cnt_reg == LAST_BIT) begin
            // Last bit: publish the full word; counter parks at WIDTH-1.
            sum_reg   <= {fa_sum, acc_reg[WIDTH-1:1]};
            cout_reg  <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_reg is the carry into the MSB at this point.
            ovf_reg   <= carry_reg ^ fa_carry;
`endif
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake flags are decoded from state only; no input-to-output paths.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH 8, 2, 32.
// Expected results are pushed to a scoreboard queue on each accept and popped
// when the DUT presents its result.
module tb_serial_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(2))  if2 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bail(input string tag);
    miscompares++;
    $display("FAIL %s: timeout waiting on DUT", tag);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "aborted after timeout");
  endtask

  // Reference model: plain integer addition of zero-extended operands.
  task automatic push_exp(input int w, input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] full;
    logic [31:0] mask;
    exp_t        e;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full   = 33'(a) + 33'(b) + 33'(c);
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    sb_q.push_back(e);
  endtask

  task automatic pop_exp(input string tag, output exp_t e);
    if (sb_q.size() == 0) begin
      bail({tag, "_empty_scoreboard"});
    end
    e = sb_q.pop_front();
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n;
    n = 0;
    @(negedge clk);
    while (!if8.in_ready) begin
      n++;
      if (n > 100) bail("send8");
      @(negedge clk);
    end
    if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1'b1;
    @(posedge clk);
    push_exp(8, 32'(a), 32'(b), c);
    #1 if8.in_valid = 1'b0;
  endtask

  // Waits for out_valid; n counts cycles after the accept edge (cycle 1 first).
  task automatic recv8(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 200) bail(tag);
    end while (!if8.out_valid);
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_in_ready_busy"}, 32'(if8.in_ready), 32'd0);
    pop_exp(tag, e);
    check({tag, "_sum"}, 32'(if8.sum), e.sum);
    check({tag, "_cout"}, 32'(if8.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(if8.ovf), 32'(e.ovf));
`endif
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1 if8.out_ready = 1'b0;
  endtask

  initial begin
    int          n;
    exp_t        e;
    logic [31:0] ra, rb;
    logic        rc;
    time         t_acc, t_prev;

    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    if8.in_valid = 0;  if8.a = '0;  if8.b = '0;  if8.cin = 0;  if8.out_ready = 0;
    if2.in_valid = 0;  if2.a = '0;  if2.b = '0;  if2.cin = 0;  if2.out_ready = 0;
    if32.in_valid = 0; if32.a = '0; if32.b = '0; if32.cin = 0; if32.out_ready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(if8.in_ready), 32'd1);
    check("rst_out_valid", 32'(if8.out_valid), 32'd0);
    check("rst_sum", 32'(if8.sum), 32'd0);
    check("rst_cout", 32'(if8.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(if8.ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // Directed operations at WIDTH=8
    send8(8'h05, 8'h03, 1'b0); recv8("add_05_03", 9);
    send8(8'hFF, 8'h01, 1'b0); recv8("add_ff_01", 9);
    send8(8'h7F, 8'h01, 1'b0); recv8("add_7f_01", -1);
    send8(8'hFF, 8'hFF, 1'b1); recv8("add_ff_ff_c", -1);
    send8(8'h80, 8'h80, 1'b0); recv8("add_80_80", -1);

    // Consumer stall: result and flags must stay put while inputs wiggle
    send8(8'h12, 8'h34, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 200) bail("stall_wait");
    end while (!if8.out_valid);
    e = sb_q[0];
    for (int i = 0; i < 5; i++) begin
      if8.in_valid = ~if8.in_valid;
      if8.a = 8'($urandom);
      if8.b = 8'($urandom);
      if8.cin = ~if8.cin;
      @(negedge clk);
      check("stall_sum", 32'(if8.sum), e.sum);
      check("stall_cout", 32'(if8.cout), 32'(e.cout));
      check("stall_in_ready", 32'(if8.in_ready), 32'd0);
      check("stall_out_valid", 32'(if8.out_valid), 32'd1);
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1 if8.out_ready = 1'b0;
    pop_exp("stall", e);
    check("release_out_valid", 32'(if8.out_valid), 32'd0);
    check("release_in_ready", 32'(if8.in_ready), 32'd1);
    check("release_sum", 32'(if8.sum), e.sum);

    // Reset in the middle of SHIFT
    send8(8'hAA, 8'h55, 1'b1);
    repeat (4) @(negedge clk);
    check("midshift_busy", 32'(if8.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("midrst_out_valid", 32'(if8.out_valid), 32'd0);
    check("midrst_in_ready", 32'(if8.in_ready), 32'd1);
    check("midrst_sum", 32'(if8.sum), 32'd0);
    check("midrst_cout", 32'(if8.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send8(8'h10, 8'h20, 1'b0); recv8("after_rst", 9);

    // Random back-to-back at WIDTH=2, out_ready tied high
    if2.out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      @(negedge clk);
      while (!if2.in_ready) begin
        n++;
        if (n > 100) bail("w2_send");
        @(negedge clk);
      end
      ra = $urandom & 32'h3; rb = $urandom & 32'h3; rc = 1'($urandom_range(0, 1));
      if2.a = ra[1:0]; if2.b = rb[1:0]; if2.cin = rc; if2.in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      push_exp(2, ra, rb, rc);
      if (i > 0) check("w2_period", 32'(t_acc - t_prev), 32'd40);
      t_prev = t_acc;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n > 100) bail("w2_recv");
      end while (!if2.out_valid);
      pop_exp("w2", e);
      check("w2_sum", 32'(if2.sum), e.sum);
      check("w2_cout", 32'(if2.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
      check("w2_ovf", 32'(if2.ovf), 32'(e.ovf));
`endif
    end
    if2.in_valid = 1'b0;

    // Random back-to-back at WIDTH=32, out_ready tied high
    if32.out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      @(negedge clk);
      while (!if32.in_ready) begin
        n++;
        if (n > 100) bail("w32_send");
        @(negedge clk);
      end
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if32.a = ra; if32.b = rb; if32.cin = rc; if32.in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      push_exp(32, ra, rb, rc);
      if (i > 0) check("w32_period", 32'(t_acc - t_prev), 32'd340);
      t_prev = t_acc;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n > 100) bail("w32_recv");
      end while (!if32.out_valid);
      pop_exp("w32", e);
      check("w32_sum", if32.sum, e.sum);
      check("w32_cout", 32'(if32.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
      check("w32_ovf", 32'(if32.ovf), 32'(e.ovf));
`endif
    end
    if32.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that takes two parallel operands and a carry-in through a valid/ready handshake. It streams them LSB-first through a single one-bit full-adder cell, using a registered carry. The parallel sum and carry-out are returned through a second valid/ready handshake. It sits between operand-producing logic and any consumer that trades latency for area, reusing one full-adder cell in place of a WIDTH-bit ripple chain.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present on a/b/cin.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A (unsigned; two's complement when overflow feature enabled).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, a + b + cin modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE; reset state IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load shift registers sa<=a, sb<=b, carry<=cin, bit counter<=0; go to SHIFT.
- SHIFT, one bit per cycle:
  - s = sa[0]^sb[0]^carry; carry <= majority(sa[0],sb[0],carry).
  - sa, sb shift right. s shifts into MSB of sum register (result shift right).
  - Counter increments.
  - When counter reaches WIDTH-1 in this cycle, go to DONE.
- DONE:
  - out_valid=1; sum register and cout=carry are held stable.
  - On out_ready: go to IDLE.
- in_ready is 0 in SHIFT and DONE. Inputs there are ignored and never sampled.
- out_valid is 0 except in DONE. sum/cout hold their last result after leaving DONE.
- Counter width: $clog2(WIDTH) bits; it never wraps past WIDTH-1.
- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0, ovf=0. Internal carry, counter and shift registers are 0.
- Reset mid-SHIFT or mid-DONE: immediate return to IDLE, partial result discarded, outputs at reset values.
- out_ready held high in DONE: one-cycle out_valid pulse.
- out_ready low in DONE: stall indefinitely with result stable.

## Timing
- Accept edge = cycle 0. SHIFT occupies cycles 1..WIDTH. out_valid rises WIDTH+1 cycles after the accept edge.
- Minimum operation period is WIDTH+2 cycles, with out_ready high. There is no overlap: the next operand is accepted no earlier than the cycle after the result handshake.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. All outputs are registered or decoded from state only.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Port ovf exists.
  - During the final SHIFT cycle, ovf <= carry_into_msb ^ carry_out_of_msb.
  - Valid with out_valid; cleared to 0 by reset.
- SERIAL_ADDER_OVF_EN undefined:
  - No ovf port and no extra register.
  - All other behaviour is identical.

## Structure
- Package serial_adder_pkg holds:
  - state enum typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default WIDTH constant.
- Sub-module fa_bit: purely combinational one-bit full adder (a, b, cin -> sum, carry). Instantiated once, driven by sa[0], sb[0] and the carry register.
- Top level holds FSM, counter, shift registers and carry flip-flop.

## Test plan
- WIDTH=8, a=8'h05, b=8'h03, cin=0 -> out_valid exactly 9 cycles after accept; sum=8'h08, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. With OVF_EN: ovf=0. Also a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Hold out_ready=0 for 5 cycles in DONE, toggling in_valid/a/b meanwhile -> sum/cout stable, in_ready=0, no new accept; release -> IDLE next cycle.
- Assert rst_n=0 at SHIFT cycle 4, then release -> out_valid=0, in_ready=1, sum=0. The next operation (a=8'h10, b=8'h20) returns 8'h30 normally.
- Random back-to-back operations with out_ready tied high, 1000 vectors each at WIDTH=2 and WIDTH=32 -> results match a reference model; period is exactly WIDTH+2 cycles.
